// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM read-port arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;
  localparam int          WORD_SHIFT        = 2;

  // ROM word index of a byte address inside the .text window.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/rom_addr_check.sv
// Combinational legality check of a byte address against the ROM window.
module rom_addr_check #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0040_0000),
  parameter int                    DEPTH      = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  misaligned,
  output logic                  out_of_range,
  output logic                  err
);

  // One extra bit so BASE_ADDR + 4*DEPTH cannot wrap at the top of the space.
  localparam logic [ADDR_WIDTH:0] LO_BOUND = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_BOUND = LO_BOUND + ((ADDR_WIDTH+1)'(DEPTH) << 2);

  logic [ADDR_WIDTH:0] addr_ext;

  // Classify the address: word alignment, then window bounds.
  always_comb begin
    addr_ext     = {1'b0, addr};
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (addr_ext < LO_BOUND) || (addr_ext >= HI_BOUND);
    err          = misaligned || out_of_range;
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the combinational program-ROM read port between instruction fetch
// and load/store. Each access is IDLE/RESP -> READ -> RESP.
// Optional macro ROM_ARB_RR_EN: round-robin tie-break instead of fixed LS > IF.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  err_pend_q, err_pend_d;
  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic                  if_err_q, if_err_d, ls_err_q, ls_err_d;
`ifdef ROM_ARB_RR_EN
  logic                  last_q, last_d;
`endif

  logic                  any_req;
  logic                  pick;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  chk_mis, chk_oor, chk_err, sel_err;
  logic                  flushed;

  rom_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH      (DEPTH)
  ) u_check (
    .addr         (sel_addr),
    .misaligned   (chk_mis),
    .out_of_range (chk_oor),
    .err          (chk_err)
  );

  // Choose the winning requester and its address for this cycle.
  always_comb begin
    any_req = if_req | ls_req;
`ifdef ROM_ARB_RR_EN
    if (if_req && ls_req) pick = ~last_q;
    else                  pick = ls_req ? OWN_LS : OWN_IF;
`else
    pick = ls_req ? OWN_LS : OWN_IF;
`endif
    sel_addr = (pick == OWN_LS) ? ls_addr : if_addr;
    sel_err  = chk_err | chk_mis | chk_oor;
  end

  // Next-state logic for the access sequencer and the response registers.
  // NOTE: every _d gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    err_pend_d = err_pend_q;
    flush_d    = flush_q;
    rom_addr_d = rom_addr_q;
    if_gnt_d   = 1'b0;
    ls_gnt_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_err_d   = if_err_q;
    ls_err_d   = ls_err_q;
`ifdef ROM_ARB_RR_EN
    last_d     = last_q;
`endif
    flushed    = flush_q | ((owner_q == OWN_IF) & if_flush);

    case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d    = READ;
          owner_d    = pick;
          err_pend_d = sel_err;
          flush_d    = 1'b0;
          if (!sel_err) rom_addr_d = sel_addr;
          if (pick == OWN_LS) ls_gnt_d = 1'b1;
          else                if_gnt_d = 1'b1;
`ifdef ROM_ARB_RR_EN
          last_d     = pick;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = RESP;
        flush_d = flushed;
        if (owner_q == OWN_LS) begin
          ls_rdata_d = err_pend_q ? '0 : rom_q;
          ls_err_d   = err_pend_q;
        end else if (!flushed) begin
          // A cancelled fetch is not a response, so the old word is kept.
          if_rdata_d = err_pend_q ? '0 : rom_q;
          if_err_d   = err_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      err_pend_q <= 1'b0;
      flush_q    <= 1'b0;
      rom_addr_q <= BASE_ADDR;
      if_gnt_q   <= 1'b0;
      ls_gnt_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_err_q   <= 1'b0;
      ls_err_q   <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_q     <= OWN_IF;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      err_pend_q <= err_pend_d;
      flush_q    <= flush_d;
      rom_addr_q <= rom_addr_d;
      if_gnt_q   <= if_gnt_d;
      ls_gnt_q   <= ls_gnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_err_q   <= if_err_d;
      ls_err_q   <= ls_err_d;
`ifdef ROM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  // Output mapping; a fetch response is dropped if flush is seen at any point.
  always_comb begin
    if_gnt    = if_gnt_q;
    ls_gnt    = ls_gnt_q;
    if_rvalid = (state_q == RESP) && (owner_q == OWN_IF) && !flush_q && !if_flush;
    ls_rvalid = (state_q == RESP) && (owner_q == OWN_LS);
    if_rdata  = if_rdata_q;
    ls_rdata  = ls_rdata_q;
    if_err    = if_err_q;
    ls_err    = ls_err_q;
    rom_addr  = rom_addr_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed testbench for rom_port_arbiter (default fixed-priority build).
module tb_rom_port_arbiter;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, ls_req;
  logic [31:0] if_addr, ls_addr;
  logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, busy;
  logic [31:0] if_rdata, ls_rdata, rom_addr, rom_q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ROM model: word i holds 32'h2008_0003 + i, so word 2 = 32'h2008_0005.
  always_comb rom_q = 32'h2008_0003 + ((rom_addr - BASE) >> 2);

  rom_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .rom_addr(rom_addr), .rom_q(rom_q), .busy(busy)
  );

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Flags packed as {if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy}.
  function automatic logic [4:0] flags();
    return {if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy};
  endfunction

  task automatic test_reset();
    reset = 1'b1; if_req = 0; ls_req = 0; if_flush = 0;
    if_addr = '0; ls_addr = '0;
    cyc(); cyc();
    n_cmp++;
    if (flags() !== 5'b00000) begin
      n_bad++; $display("FAIL reset_flags got %b want 00000", flags());
    end
    n_cmp++;
    if ({if_rdata, ls_rdata, if_err, ls_err} !== 66'd0) begin
      n_bad++; $display("FAIL reset_data got %h %h %b %b want 0", if_rdata, ls_rdata, if_err, ls_err);
    end
    n_cmp++;
    if (rom_addr !== BASE) begin
      n_bad++; $display("FAIL reset_rom_addr got %h want %h", rom_addr, BASE);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single_fetch(input logic [31:0] addr, input logic [31:0] exp_data);
    if_req = 1'b1; if_addr = addr;
    cyc();
    n_cmp++;
    if ({flags(), rom_addr} !== {5'b10001, addr}) begin
      n_bad++; $display("FAIL fetch_gnt got %b %h want 10001 %h", flags(), rom_addr, addr);
    end
    if_req = 1'b0;
    cyc();
    n_cmp++;
    if ({flags(), rom_addr, if_rdata, if_err} !== {5'b00101, addr, exp_data, 1'b0}) begin
      n_bad++; $display("FAIL fetch_rvalid got %b %h %h %b want 00101 %h %h 0",
                        flags(), rom_addr, if_rdata, if_err, addr, exp_data);
    end
    cyc();
    n_cmp++;
    if ({flags(), if_rdata} !== {5'b00000, exp_data}) begin
      n_bad++; $display("FAIL fetch_idle got %b %h want 00000 %h", flags(), if_rdata, exp_data);
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp_f [4] = '{5'b01001, 5'b00011, 5'b10001, 5'b00101};
    if_req = 1'b1; if_addr = BASE;
    ls_req = 1'b1; ls_addr = BASE + 32'd4;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 0) ls_req = 1'b0;
      if (i == 2) if_req = 1'b0;
      n_cmp++;
      if (flags() !== exp_f[i]) begin
        n_bad++; $display("FAIL contention_step%0d got %b want %b", i, flags(), exp_f[i]);
      end
    end
    n_cmp++;
    if ({ls_rdata, if_rdata} !== {32'h2008_0004, 32'h2008_0003}) begin
      n_bad++; $display("FAIL contention_data got %h %h want 20080004 20080003", ls_rdata, if_rdata);
    end
    cyc();
  endtask

  task automatic test_ls_access(input string name, input logic [31:0] addr,
                                input logic exp_err, input logic [31:0] exp_data);
    logic [31:0] prev_rom;
    prev_rom = rom_addr;
    ls_req = 1'b1; ls_addr = addr;
    cyc();
    ls_req = 1'b0;
    n_cmp++;
    if ({flags(), rom_addr} !== {5'b01001, exp_err ? prev_rom : addr}) begin
      n_bad++; $display("FAIL %s_gnt got %b %h want 01001 %h", name, flags(), rom_addr,
                        exp_err ? prev_rom : addr);
    end
    cyc();
    n_cmp++;
    if ({flags(), ls_err, ls_rdata} !== {5'b00011, exp_err, exp_data}) begin
      n_bad++; $display("FAIL %s_resp got %b %b %h want 00011 %b %h", name, flags(), ls_err,
                        ls_rdata, exp_err, exp_data);
    end
    cyc();
  endtask

  task automatic test_flush();
    logic [31:0] old_data;
    old_data = if_rdata;
    if_req = 1'b1; if_addr = BASE + 32'h10;
    cyc();
    n_cmp++;
    if (flags() !== 5'b10001) begin
      n_bad++; $display("FAIL flush_gnt got %b want 10001", flags());
    end
    if_req = 1'b0; if_flush = 1'b1;
    cyc();
    if_flush = 1'b0;
    #1;
    n_cmp++;
    if ({flags(), if_rdata} !== {5'b00001, old_data}) begin
      n_bad++; $display("FAIL flush_resp got %b %h want 00001 %h", flags(), if_rdata, old_data);
    end
    cyc();
    n_cmp++;
    if (flags() !== 5'b00000) begin
      n_bad++; $display("FAIL flush_idle got %b want 00000", flags());
    end
  endtask

  task automatic test_reset_mid_op();
    if_req = 1'b1; if_addr = BASE + 32'h4;
    cyc();
    if_req = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_cmp++;
    if ({flags(), if_rdata, ls_rdata, if_err, ls_err, rom_addr} !== {5'b00000, 66'd0, BASE}) begin
      n_bad++; $display("FAIL midreset got %b %h %h %b %b %h want all 0 rom %h", flags(),
                        if_rdata, ls_rdata, if_err, ls_err, rom_addr, BASE);
    end
    cyc();
    n_cmp++;
    if (flags() !== 5'b00000) begin
      n_bad++; $display("FAIL midreset_after got %b want 00000", flags());
    end
    test_single_fetch(BASE + 32'h8, 32'h2008_0005);
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = BASE;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (flags() !== 5'b10001) begin
        n_bad++; $display("FAIL b2b_gnt%0d got %b want 10001", i, flags());
      end
      if (i == 2) if_req = 1'b0;
      else        if_addr = BASE + 32'(4 * (i + 1));
      cyc();
      n_cmp++;
      if ({flags(), if_rdata} !== {5'b00101, 32'h2008_0003 + 32'(i)}) begin
        n_bad++; $display("FAIL b2b_resp%0d got %b %h want 00101 %h", i, flags(), if_rdata,
                          32'h2008_0003 + 32'(i));
      end
    end
    cyc();
    n_cmp++;
    if (flags() !== 5'b00000) begin
      n_bad++; $display("FAIL b2b_idle got %b want 00000", flags());
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch(BASE + 32'h8, 32'h2008_0005);
    test_contention();
    test_ls_access("ls_misaligned", 32'h0040_0002, 1'b1, 32'h0);
    test_ls_access("ls_above",      32'h0040_0100, 1'b1, 32'h0);
    test_ls_access("ls_below",      32'h003F_FFFC, 1'b1, 32'h0);
    test_ls_access("ls_last_word",  32'h0040_00FC, 1'b0, 32'h2008_0042);
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Sequences the single read port of the program ROM and shares it between two requesters: instruction fetch (IF) and load/store data read (LS).
- The ROM is combinational: address in, word out, with `.text` starting at BASE_ADDR.
- This block registers the grant, performs the ROM read, returns data with a valid pulse, and flags illegal addresses without touching the ROM.

Parameters:
- DATA_WIDTH, 32, width of ROM word and read data.
- ADDR_WIDTH, 32, width of byte addresses.
- BASE_ADDR, 32'h0040_0000, byte address of ROM word 0.
- DEPTH, 64, number of ROM words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; hold with if_addr stable until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_flush  in  1  cancel any outstanding fetch response.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata/if_err valid.
- if_rdata  out  DATA_WIDTH  fetched word.
- if_err  out  1  fetch address misaligned or out of range.
- ls_req  in  1  data read request; same hold rule.
- ls_addr  in  ADDR_WIDTH  data byte address.
- ls_gnt  out  1  one-cycle pulse: data request accepted.
- ls_rvalid  out  1  one-cycle pulse: ls_rdata/ls_err valid.
- ls_rdata  out  DATA_WIDTH  read word.
- ls_err  out  1  data address misaligned or out of range.
- rom_addr  out  ADDR_WIDTH  byte address driven to the ROM.
- rom_q  in  DATA_WIDTH  combinational ROM output.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- **Reset:**
  - All outputs are 0.
  - rom_addr = BASE_ADDR.
  - State = IDLE; the owner register is cleared.
  - Asserting reset mid-transaction drops that transaction; no rvalid is ever produced for it.
- **States:** IDLE, READ, RESP.
- **IDLE:**
  - If any req is high: arbitrate, latch the winner's address and owner id, pulse the winner's gnt in the next cycle, and go to READ.
  - Otherwise stay in IDLE.
- **READ:**
  - rom_addr = latched address.
  - At the edge, capture rom_q into the owner's rdata register, set err, and go to RESP.
- **RESP:**
  - Owner's rvalid = 1 for exactly one cycle.
  - If any req is high: arbitrate and go to READ (back-to-back service).
  - Otherwise go to IDLE.
- **Timing:**
  - Latency is req sampled at edge N → gnt high in cycle N+1 → rvalid high in cycle N+2.
  - Peak throughput is one access per 2 cycles.
- **Priority (default):** fixed, LS over IF; IF waits while LS is held high.
- **Address check** (combinational at latch time):
  - err if addr[1:0] != 0, or addr < BASE_ADDR, or addr >= BASE_ADDR + 4*DEPTH.
  - ROM word index = (addr - BASE_ADDR) >> 2; rom_addr carries the full byte address.
  - On err: rdata = 0, err = 1, rvalid still pulses with the same latency; rom_addr stays at its previous value.
- **rdata/err hold:** hold their value until the next response to that requester.
- **Flush:**
  - if_flush high in any cycle while the IF transaction is in READ or RESP suppresses if_rvalid for that transaction; the state sequence is unchanged.
  - if_flush in IDLE has no effect.
  - if_flush has no effect on LS.
- **Simultaneous events:**
  - Both reqs high → priority rule applies.
  - A req asserted during READ is only considered in RESP.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- **Defined:** round-robin arbitration. A 1-bit last-winner register is reset to IF (so LS wins the first tie). On a tie, the requester that did not win last is granted.
- **Undefined:** fixed LS-over-IF priority; no last-winner register is present.

Decomposition:
- **Package rom_arb_pkg:**
  - state enum {IDLE, READ, RESP}.
  - Owner id constants OWN_IF = 1'b0, OWN_LS = 1'b1.
  - Default BASE_ADDR and word-offset shift constant.
- **Sub-module rom_addr_check:**
  - Combinational.
  - Input: addr.
  - Outputs: misaligned, out_of_range, err.
  - Parameterised by BASE_ADDR and DEPTH.

Test Plan:
- **Single fetch:** if_req=1, if_addr=32'h0040_0008, ROM word2=32'h2008_0005 → if_gnt in cycle 1, rom_addr=32'h0040_0008 in cycle 2, if_rvalid=1 and if_rdata=32'h2008_0005 in cycle 2, if_err=0.
- **Contention:** if_req and ls_req both high at 0x0040_0000 and 0x0040_0004.
  - Default build: ls_gnt first; ls_rvalid, then if_gnt; if_rvalid two cycles later; busy high throughout.
  - With ROM_ARB_RR_EN, repeated contention alternates LS, IF, LS.
- **Errors:**
  - ls_addr=32'h0040_0002 → ls_rvalid at the standard latency, ls_err=1, ls_rdata=0.
  - ls_addr=32'h0040_0100 (DEPTH=64) → ls_err=1.
  - ls_addr=32'h003F_FFFC → ls_err=1.
- **Flush:** if_req at 0x0040_0010, if_flush pulsed in the READ cycle → if_gnt seen, if_rvalid never asserts, state returns to IDLE after RESP.
- **Reset mid-op:** reset asserted in the READ cycle → next cycle all outputs 0, rom_addr=32'h0040_0000, no rvalid, busy=0; a fresh request afterwards completes normally.
- **Back-to-back:** if_req held with if_addr stepping 0x0040_0000, 0x0040_0004, 0x0040_0008 → if_rvalid every 2 cycles with words 0, 1, 2; IDLE never entered.
